// File: rtl/dlx_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dlx_mem_pkg : shared types and constants for the DLX unified memory port  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic        REQ_IF          = 1'b0;
  localparam logic        REQ_MEM         = 1'b1;
  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned WCNT_W          = 4;

  // Out-of-range wait-state settings saturate at the counter's capacity.
  function automatic logic [WCNT_W-1:0] clamp_wait(input int unsigned ws);
    return (ws > MAX_WAIT_STATES) ? WCNT_W'(MAX_WAIT_STATES) : WCNT_W'(ws);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_wait_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_wait_cnt : loadable down-counter timing SRAM wait states              |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module arb_wait_cnt
  import dlx_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WCNT_W-1:0] load_val,
  input  logic              en,
  output logic              zero
);

  logic [WCNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter : shares one SRAM port between DLX fetch and data stages |
// | Optional macro MEM_ARB_RR_EN selects round-robin instead of MEM priority. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam logic [1:0]        c_idle   = IDLE;
  localparam logic [1:0]        c_access = ACCESS;
  localparam logic [1:0]        c_resp   = RESP;
  localparam logic [WCNT_W-1:0] c_wait   = clamp_wait(WAIT_STATES);

  logic [1:0]        r_state;
  logic              r_gnt;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;

  logic w_any_req;
  logic w_winner;
  logic w_wcnt_zero;
  logic w_wcnt_load;
  logic w_access;
  logic w_write;

  assign w_any_req = if_req | mem_req;

`ifdef MEM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= REQ_IF;
    end else if (r_state == c_resp) begin
      r_last <= r_gnt;
    end
  end

  // On a tie the requester that was not served most recently wins.
  assign w_winner = (if_req && mem_req) ? ~r_last : (mem_req ? REQ_MEM : REQ_IF);
`else
  // MEM holds the older instruction, so it always wins a tie.
  assign w_winner = mem_req ? REQ_MEM : REQ_IF;
`endif

  assign w_wcnt_load = (r_state == c_idle) && w_any_req;
  assign w_access    = (r_state == c_access);
  assign w_write     = (r_gnt == REQ_MEM) && mem_we;

  arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (w_wcnt_load),
    .load_val (c_wait),
    .en       (w_access),
    .zero     (w_wcnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_idle;
      r_gnt       <= REQ_IF;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_any_req) begin
            r_gnt   <= w_winner;
            r_state <= c_access;
          end
        end
        c_access: begin
          if (w_wcnt_zero) begin
            if (!w_write) begin
              if (r_gnt == REQ_MEM) begin
                r_mem_rdata <= sram_dout;
              end else begin
                r_if_rdata  <= sram_dout;
              end
            end
            r_state <= c_resp;
          end
        end
        c_resp:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign sram_cs   = w_access;
  assign sram_we   = w_access & w_write;
  assign sram_oe   = w_access & ~w_write;
  assign sram_addr = w_access ? ((r_gnt == REQ_MEM) ? mem_addr : if_addr) : '0;
  assign sram_din  = w_access ? mem_wdata : '0;

  assign if_ready  = (r_state == c_resp) && (r_gnt == REQ_IF);
  assign mem_ready = (r_state == c_resp) && (r_gnt == REQ_MEM);
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter : randomized check of two arbiters (0 and 3 waits)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit done [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Initial SRAM image: every word distinct and derived from its index.
  function automatic logic [31:0] pattern(input logic [7:0] i);
    return {8'hC0, i, ~i, i ^ 8'h5A};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int WS = (g == 0) ? 0 : 3;

    logic        reset, if_req, if_ready, mem_req, mem_we, mem_ready;
    logic        sram_cs, sram_oe, sram_we;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] sram_addr, sram_din, sram_dout;

    bit          wr_valid [256];
    logic [31:0] wr_data  [256];
    logic [31:0] ref_st [int];
    logic [31:0] exp_if_rdata, exp_mem_rdata;
    bit          last_mem;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS)) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready),
      .if_rdata  (if_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .sram_cs   (sram_cs),
      .sram_oe   (sram_oe),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout)
    );

    assign sram_dout = wr_valid[sram_addr[9:2]] ? wr_data[sram_addr[9:2]] : pattern(sram_addr[9:2]);

    always @(posedge clk) begin
      if (sram_cs && sram_we) begin
        wr_valid[sram_addr[9:2]] <= 1'b1;
        wr_data[sram_addr[9:2]]  <= sram_din;
      end
    end

    function automatic string tg(input string s);
      return $sformatf("ws%0d_%s", WS, s);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
      int i = int'(a[9:2]);
      return ref_st.exists(i) ? ref_st[i] : pattern(a[9:2]);
    endfunction

    task automatic drive_idle();
      if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic check_all_zero(input string s);
      check_val(tg({s, "_bus"}), {sram_cs, sram_oe, sram_we, if_ready, mem_ready}, 32'h0);
      check_val(tg({s, "_addr"}), sram_addr, 32'h0);
      check_val(tg({s, "_din"}), sram_din, 32'h0);
      check_val(tg({s, "_if_rdata"}), if_rdata, 32'h0);
      check_val(tg({s, "_mem_rdata"}), mem_rdata, 32'h0);
    endtask

    // One arbitration round started from an idle arbiter; called at a negedge.
    task automatic run_round(input bit do_if, input bit do_mem, input bit we,
                             input logic [31:0] ia, input logic [31:0] ma,
                             input logic [31:0] wd, input bit drop_early);
      bit first_mem, first_done, serving_mem;
      int t_if = -1, t_mem = -1, n_if = 0, n_mem = 0;
      int n_cs = 0, n_we = 0, bad_acc = 0, bad_idle = 0;
      int budget = 2 * (WS + 3) + 4;
      int exp_if_t, exp_mem_t;
      if (do_if && do_mem) first_mem = RR ? !last_mem : 1'b1;
      else                 first_mem = do_mem;
      first_done = 1'b0;
      if_req = do_if; if_addr = ia;
      mem_req = do_mem; mem_we = we; mem_addr = ma; mem_wdata = wd;
      for (int c = 1; c <= budget; c++) begin
        @(negedge clk);
        if (sram_cs === 1'b1) begin
          n_cs++;
          if (sram_we === 1'b1) n_we++;
          serving_mem = first_done ? !first_mem : first_mem;
          if (sram_addr !== (serving_mem ? ma : ia) || sram_din !== wd ||
              sram_we !== (serving_mem && we) || sram_oe !== !(serving_mem && we))
            bad_acc++;
        end else if (sram_oe !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 32'h0 || sram_din !== 32'h0) begin
          bad_idle++;
        end
        if (if_ready === 1'b1) begin
          n_if++;
          if (t_if < 0) begin
            t_if = c;
            exp_if_rdata = ref_rd(ia);
            check_val(tg("if_rdata"), if_rdata, exp_if_rdata);
            if_req = 1'b0;
            last_mem = 1'b0;
            if (!first_mem) first_done = 1'b1;
          end
        end
        if (mem_ready === 1'b1) begin
          n_mem++;
          if (t_mem < 0) begin
            t_mem = c;
            if (we) begin
              check_val(tg("mem_rdata_store_hold"), mem_rdata, exp_mem_rdata);
              ref_st[int'(ma[9:2])] = wd;
            end else begin
              exp_mem_rdata = ref_rd(ma);
              check_val(tg("mem_rdata"), mem_rdata, exp_mem_rdata);
            end
            mem_req = 1'b0;
            last_mem = 1'b1;
            if (first_mem) first_done = 1'b1;
          end
        end
        if (drop_early && c == 1) begin
          if_req = 1'b0;
          mem_req = 1'b0;
        end
      end
      exp_if_t  = !do_if  ? -1 : ((do_mem && first_mem)  ? 2 * WS + 5 : WS + 2);
      exp_mem_t = !do_mem ? -1 : ((do_if  && !first_mem) ? 2 * WS + 5 : WS + 2);
      check_val(tg("if_latency"), t_if, exp_if_t);
      check_val(tg("mem_latency"), t_mem, exp_mem_t);
      check_val(tg("if_pulses"), n_if, {31'b0, do_if});
      check_val(tg("mem_pulses"), n_mem, {31'b0, do_mem});
      check_val(tg("cs_cycles"), n_cs, (int'(do_if) + int'(do_mem)) * (WS + 1));
      check_val(tg("we_cycles"), n_we, (do_mem && we) ? WS + 1 : 0);
      check_val(tg("access_bus"), bad_acc, 0);
      check_val(tg("idle_bus"), bad_idle, 0);
      check_val(tg("if_rdata_hold"), if_rdata, exp_if_rdata);
      check_val(tg("mem_rdata_hold"), mem_rdata, exp_mem_rdata);
      drive_idle();
    endtask

    // Fetch held high across four back-to-back words at 0, 4, 8, 12.
    task automatic run_burst();
      int t_prev = 0, k = 0;
      if_req = 1'b1; if_addr = 32'h0;
      for (int c = 1; c <= 4 * (WS + 3) + 6; c++) begin
        @(negedge clk);
        if (if_ready === 1'b1) begin
          check_val(tg("burst_data"), if_rdata, ref_rd(32'(k * 4)));
          check_val(tg("burst_gap"), c - t_prev, (k == 0) ? WS + 2 : WS + 3);
          exp_if_rdata = ref_rd(32'(k * 4));
          last_mem = 1'b0;
          t_prev = c;
          k++;
          if (k < 4) if_addr = 32'(k * 4);
          else       if_req  = 1'b0;
        end
      end
      check_val(tg("burst_count"), k, 4);
      drive_idle();
    endtask

    // Reset lands while a load is in ACCESS; nothing may complete.
    task automatic run_reset_abort();
      int n_rdy = 0;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
      @(negedge clk);
      check_val(tg("abort_in_access"), sram_cs, 1'b1);
      reset = 1'b1;
      drive_idle();
      @(negedge clk);
      check_all_zero("abort");
      reset = 1'b0;
      exp_if_rdata = '0; exp_mem_rdata = '0; last_mem = 1'b0;
      repeat (WS + 6) begin
        @(negedge clk);
        if (if_ready === 1'b1 || mem_ready === 1'b1) n_rdy++;
      end
      check_val(tg("abort_no_ready"), n_rdy, 0);
    endtask

    initial begin
      bit [1:0]    pat;
      bit          rwe, drop;
      logic [31:0] ia, ma, wd;
      reset = 1'b1;
      drive_idle();
      exp_if_rdata = '0; exp_mem_rdata = '0; last_mem = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      run_round(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
      run_round(1'b1, 1'b1, 1'b0, 32'h10, 32'h40, 32'h0, 1'b0);
      run_round(1'b1, 1'b1, 1'b0, 32'h14, 32'h44, 32'h0, 1'b0);
      run_round(1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 32'hDEADBEEF, 1'b0);
      run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 1'b0);
      run_round(1'b1, 1'b1, 1'b0, 32'h20, 32'h80, 32'h0, 1'b0);
      run_reset_abort();
      run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 1'b0);
      run_burst();
      for (int r = 0; r < 40; r++) begin
        pat  = 2'($urandom_range(1, 3));
        rwe  = 1'($urandom_range(0, 1));
        ia   = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        ma   = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        wd   = $urandom;
        drop = (pat != 2'd3) && ($urandom_range(0, 3) == 0);
        run_round(pat[0], pat[1], rwe, ia, ma, wd, drop);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done[0] && done[1]) break;
    end
    if (!(done[0] && done[1])) check_val("run_timeout", 32'h0, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single `sram` port between the instruction-fetch stage and the data-memory stage of the DLX pipeline, so both can live in one unified memory image. Each requester presents a request/address and is held off until a one-cycle `*_ready` pulse returns its read data. Configurable wait states model slower memory; the pipeline stalls fetch or memory on a low `*_ready`.

## Interface
- `ADDR_W`, 32, address width (byte address passed straight to `sram.addr`)
- `DATA_W`, 32, data width
- `WAIT_STATES`, 0, extra access cycles per transaction (0..15)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held high until `if_ready`
- `if_addr`  in  ADDR_W  fetch address (PC); stable while `if_req`
- `if_ready`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid
- `if_rdata`  out  DATA_W  registered instruction word
- `mem_req`  in  1  data request; held high until `mem_ready`
- `mem_we`  in  1  1 = store, 0 = load; stable while `mem_req`
- `mem_addr`  in  ADDR_W  data address
- `mem_wdata`  in  DATA_W  store data
- `mem_ready`  out  1  one-cycle pulse: data access complete
- `mem_rdata`  out  DATA_W  registered load data (unchanged on stores)
- `sram_cs`, `sram_oe`, `sram_we`  out  1  SRAM controls
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_din`  out  DATA_W  SRAM write data
- `sram_dout`  in  DATA_W  SRAM read data (combinational)

## Operation
- FSM states: IDLE, ACCESS, RESP. Owner register `gnt` (IF or MEM) and wait counter `wcnt`.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the winner into `gnt`, load `wcnt = WAIT_STATES`, go to ACCESS.
- ACCESS:
  - Drive `sram_cs = 1`, `sram_addr` = owner address, `sram_oe = ~write`, `sram_we = write` (IF is never a write), `sram_din = mem_wdata`.
  - `wcnt != 0`: decrement.
  - `wcnt == 0`: on reads, capture `sram_dout` into the owner's `*_rdata`; go to RESP.
- RESP: assert the owner's `*_ready` for exactly one cycle; SRAM controls are 0; go to IDLE.
- Arbitration (default): fixed priority, MEM over IF, because MEM holds the older instruction. IF can starve only while MEM requests continuously; the pipeline cannot cause this.
- Requester rule: `*_req` stays high after `*_ready` only if it is a new request; address and data update in the cycle after `*_ready`.
- Outside ACCESS, all SRAM controls are 0 and `sram_addr`/`sram_din` are 0.
- `*_rdata` holds its value until the next read completes for that requester.

## Timing
- Reset values: state IDLE, `gnt` IF, `wcnt` 0, both `*_ready` 0, both `*_rdata` 0, all `sram_*` outputs 0.
- Latency: request sampled high in IDLE at edge k → ACCESS for cycles k+1 … k+1+WAIT_STATES → `*_ready` high in cycle k+2+WAIT_STATES.
- Throughput: one access per WAIT_STATES+3 cycles; RESP always returns to IDLE before re-arbitrating.
- Simultaneous `if_req` and `mem_req` in IDLE: resolved by the arbitration rule. The loser keeps waiting, with no lost request.
- A request that drops during ACCESS (illegal) is still completed, and `*_ready` still pulses.
- `reset` in any state: next cycle IDLE with reset values. An in-flight store may have been partially driven, and the requester must re-issue it. No `*_ready` is produced for an aborted access.
- `WAIT_STATES = 0`: ACCESS lasts exactly one cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a simultaneous request, the requester not served last wins. A `last` flag (reset value IF) updates in RESP.
- Not defined: fixed MEM-over-IF priority as above, and the `last` flag is not built.

## Structure
- Shared package `dlx_mem_pkg`:
  - state enum {IDLE, ACCESS, RESP}
  - requester id constants `REQ_IF = 1'b0`, `REQ_MEM = 1'b1`
  - `MAX_WAIT_STATES = 15`
- Sub-module `arb_wait_cnt`: loadable 4-bit down-counter with `load`, `en`, and `zero` outputs. The FSM, grant logic and output muxing stay in `mem_port_arbiter`.

## Test plan
- Reset, then `if_req = 1` with `if_addr = 0x10`, WAIT_STATES = 0 → `sram_cs` in cycle 1; `if_ready` in cycle 2 with `if_rdata` equal to the word at 0x10.
- Same request with WAIT_STATES = 3 → ACCESS lasts 4 cycles; `if_ready` 5 cycles after the request is sampled.
- `if_req` and `mem_req` (load, 0x40) together → MEM is served first, then IF; `if_ready` 3 cycles after `mem_ready` (WAIT_STATES = 0). With `MEM_ARB_RR_EN` defined, after an initial MEM grant the next tie goes to IF.
- Store 0xDEADBEEF to 0x80, then load 0x80 → `sram_we = 1` for one cycle; the load returns 0xDEADBEEF; `mem_rdata` is unchanged across the store.
- Assert `reset` mid-ACCESS with WAIT_STATES = 3 → next cycle all outputs at reset values and no `*_ready` pulse; a re-issued request completes normally.
- `if_req` held high for 4 consecutive fetches (addresses 0, 4, 8, 12) → 4 `if_ready` pulses spaced 3 cycles apart with the correct words.
